// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared encodings and default vectors for fetch, CP0 and IM.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam logic [2:0] PC_SEQ = 3'b000;
  localparam logic [2:0] PC_BR  = 3'b001;
  localparam logic [2:0] PC_J   = 3'b010;
  localparam logic [2:0] PC_JR  = 3'b011;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef enum logic [0:0] {
    PS_RUN   = ST_RUN,
    PS_FLUSH = ST_FLUSH
  } pc_state_e;

  localparam logic [31:0] C_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] C_EXC_PC     = 32'h0000_4180;
  localparam logic [31:0] C_IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] C_IMEM_BYTES = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/pc_range_chk.sv
`default_nettype none
// ============================================================================
// Module   : pc_range_chk
// Brief    : Word-alignment and instruction-window check for a fetch address.
// Revision : 1.0
// ============================================================================
module pc_range_chk
  import mips_pkg::*;
#(
  parameter int          W          = 32,
  parameter logic [W-1:0] IMEM_BASE  = W'(C_IMEM_BASE),
  parameter logic [W-1:0] IMEM_BYTES = W'(C_IMEM_BYTES)
) (
  input  logic [W-1:0] addr,
  output logic         adel
);

  // One extra bit keeps base+size from wrapping at the top of the address space.
  localparam logic [W:0] C_LO = {1'b0, IMEM_BASE};
  localparam logic [W:0] C_HI = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

  logic [W:0] w_addr_ext;
  logic       w_misaligned;
  logic       w_below;
  logic       w_above;

  assign w_addr_ext   = {1'b0, addr};
  assign w_misaligned = (addr[1:0] != 2'b00);
  assign w_below      = (w_addr_ext < C_LO);
  assign w_above      = (w_addr_ext >= C_HI);
  assign adel         = w_misaligned | w_below | w_above;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Registered PC with next-PC selection, delay-slot flag and flush.
// Revision : 1.0
// ============================================================================
module pc_unit
  import mips_pkg::*;
#(
  parameter int          W          = 32,
  parameter logic [W-1:0] RESET_PC   = W'(C_RESET_PC),
  parameter logic [W-1:0] EXC_PC     = W'(C_EXC_PC),
  parameter logic [W-1:0] IMEM_BASE  = W'(C_IMEM_BASE),
  parameter logic [W-1:0] IMEM_BYTES = W'(C_IMEM_BYTES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [2:0]   pc_sel,
  input  logic         br_cond,
  input  logic [W-1:0] br_target,
  input  logic [W-1:0] j_target,
  input  logic [W-1:0] jr_target,
  input  logic         exc_req,
  input  logic         eret_req,
  input  logic [W-1:0] epc,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc4,
  output logic [W-1:0] pc8,
  output logic         bd_f,
  output logic         adel_f,
  output logic         flushing
);

  logic [W-1:0] r_pc;
  logic         r_bd;
  pc_state_e    r_state;

  logic [W-1:0] w_pc_next;
  logic         w_bd_next;
  pc_state_e    w_state_next;
  logic [W-1:0] w_pc4;

  assign w_pc4 = r_pc + W'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_bd    <= 1'b0;
      r_state <= PS_RUN;
    end else begin
      r_pc    <= w_pc_next;
      r_bd    <= w_bd_next;
      r_state <= w_state_next;
    end
  end

  // Stalls hold everything; a stalled redirect is re-presented by D, not latched here.
  always_comb begin
    w_pc_next    = r_pc;
    w_bd_next    = r_bd;
    w_state_next = r_state;
    if (exc_req) begin
      w_pc_next    = EXC_PC;
      w_bd_next    = 1'b0;
      w_state_next = PS_FLUSH;
    end else if (eret_req) begin
      w_pc_next    = epc;
      w_bd_next    = 1'b0;
      w_state_next = PS_FLUSH;
    end else if (en) begin
      if (r_state == PS_FLUSH) begin
        w_pc_next    = w_pc4;
        w_bd_next    = 1'b0;
        w_state_next = PS_RUN;
      end else begin
        w_state_next = PS_RUN;
        case (pc_sel)
          PC_BR: begin
            w_pc_next = br_cond ? br_target : w_pc4;
            w_bd_next = 1'b1;
          end
          PC_J: begin
            w_pc_next = j_target;
            w_bd_next = 1'b1;
          end
          PC_JR: begin
            w_pc_next = jr_target;
            w_bd_next = 1'b1;
          end
          default: begin
            w_pc_next = w_pc4;
            w_bd_next = 1'b0;
          end
        endcase
      end
    end
  end

  pc_range_chk #(
    .W          (W),
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_BYTES (IMEM_BYTES)
  ) u_range_chk (
    .addr (r_pc),
    .adel (adel_f)
  );

  assign pc       = r_pc;
  assign pc4      = w_pc4;
  assign pc8      = r_pc + W'(8);
  assign bd_f     = r_bd;
  assign flushing = (r_state == PS_FLUSH);

endmodule
`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Next-generation fetch-address unit for the pipelined MIPS core, at the head of the F stage. It replaces the combinational next-PC mux with one registered block.
- It owns the PC register and selects the next PC from PC+4, conditional branch, J/JAL, JR, exception-handler entry and ERET return.
- It tracks the branch-delay-slot flag and a post-redirect flush state, and flags fetch address errors.
- Data width, reset vector, handler vector and instruction-memory window are parameters.

Parameters:
- W, 32, address/data width; must be at least 16.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception handler entry address.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 32'h0000_3000, size of the legal fetch window in bytes.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  PC write enable; 0 means stall (hold).
- pc_sel  in  3  redirect request from D: 000 seq, 001 branch, 010 J/JAL, 011 JR, others treated as 000.
- br_cond  in  1  branch condition already resolved in D (eq/ne/lez/gtz/...); 1 means taken.
- br_target  in  W  branch target address.
- j_target  in  W  J/JAL target address.
- jr_target  in  W  forwarded rs value for JR/JALR.
- exc_req  in  1  exception/interrupt accepted by CP0 this cycle.
- eret_req  in  1  ERET in its commit stage this cycle.
- epc  in  W  return address from CP0.
- pc  out  W  current fetch address (the register).
- pc4  out  W  pc+4.
- pc8  out  W  pc+8, the link value for the F instruction.
- bd_f  out  1  1 if the instruction at pc is a delay slot.
- adel_f  out  1  fetch address error for pc.
- flushing  out  1  high during the FLUSH state.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, bd_f=0, state=RUN. While reset is high, all inputs are ignored.
- Combinational outputs: pc4=pc+4 and pc8=pc+8, both mod 2^W (wrap silently).
- adel_f=1 when pc[1:0]!=0, or pc<IMEM_BASE, or pc>=IMEM_BASE+IMEM_BYTES. Comparisons are unsigned and done in W+1 bits so the window end never overflows. adel_f does not change pc. CP0 raises exc_req from it.
- States: RUN and FLUSH. They are encoded as localparams in the shared package.
- Next-pc priority, evaluated at each rising edge:
  1. exc_req: pc←EXC_PC, bd_f←0, state←FLUSH. This ignores en and overrides eret_req.
  2. eret_req: pc←epc, bd_f←0, state←FLUSH. This ignores en.
  3. en=0: pc, bd_f and state all hold. A stalled redirect is re-presented by D next cycle; no redirect is latched internally.
  4. state=FLUSH: pc←pc+4, bd_f←0, state←RUN. pc_sel is ignored because the D instruction is a squashed bubble.
  5. state=RUN, en=1, by pc_sel:
     - 001 with br_cond=1: pc←br_target.
     - 001 with br_cond=0: pc←pc+4.
     - 010: pc←j_target.
     - 011: pc←jr_target.
     - else: pc←pc+4.
- bd_f update in RUN with en=1: bd_f←1 when pc_sel is 001, 010 or 011 (taken or not); otherwise bd_f←0. The delay slot always executes; it is never squashed by this block.
- Misaligned targets are loaded unmodified. The error surfaces via adel_f on the following cycle.
- Simultaneous exc_req and eret_req: the exception wins.
- flushing = (state==FLUSH).

Decomposition:
- Package mips_pkg:
  - PC_SEQ/PC_BR/PC_J/PC_JR encodings (3-bit).
  - RUN/FLUSH state encoding.
  - Default RESET_PC and EXC_PC constants, shared with CP0 and IM.
- One sub-module, pc_range_chk: a combinational alignment and window check, parametrised by W, IMEM_BASE and IMEM_BYTES. It is reused for D-stage jump-target checking.

Test Plan:
1. Reset mid-run: assert reset asynchronously between edges → pc=0x3000, bd_f=0, flushing=0 immediately. After release with en=1, pc goes 0x3004, 0x3008.
2. Branch in RUN at pc=0x3010: pc_sel=001, br_cond=1, br_target=0x3040 → next pc=0x3040, bd_f=1. Repeat with br_cond=0 → next pc=0x3014, bd_f=1.
3. Stall: en=0 for 3 cycles with pc_sel=010, j_target=0x3100 → pc holds 0x3020. When en=1 → pc=0x3100.
4. exc_req while en=0 at pc=0x3050 → pc=0x4180, flushing=1. Next cycle, with pc_sel=011 and jr_target=0x5000 → pc=0x4184 (the JR is ignored), flushing=0.
5. Simultaneous exc_req and eret_req with epc=0x3060 → pc=0x4180. Then eret_req alone with epc=0x3060 → pc=0x3060, bd_f=0.
6. Fetch address error: JR to 0x3002 → adel_f=1 next cycle. JR to 0x6000 → adel_f=1. JR to 0x5FFC → adel_f=0. With W=16, wrap from 0xFFFC gives pc4=0x0000.
